// File: rtl/sseg_scan_driver.sv
// Time-multiplexed seven-segment driver: shadowed hex value, blank-interval anti-ghosting,
// leading-zero blanking and scan-complete pulse. Define SSEG_DIM_EN to add a 4-bit PWM brightness input.
module sseg_scan_driver #(
    parameter int NUM_DIGITS   = 3,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_blank,
`ifdef SSEG_DIM_EN
    input  logic [3:0]              brightness,
`endif
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    scan_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] value_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic                    lz_q;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    scan_done_q, scan_done_d;

    logic                    slot_end;
    logic [NUM_DIGITS-1:0]   lzb;
    logic                    zero_above;
    logic [3:0]              nib_sel;
    logic                    dp_sel;
    logic                    lzb_sel;
    logic                    pwm_on;

    // Active-low {a,b,c,d,e,f,g,dp}; dp bit left off here.
    function automatic logic [7:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 8'b00000011;
            4'h1: font = 8'b10011111;
            4'h2: font = 8'b00100101;
            4'h3: font = 8'b00001101;
            4'h4: font = 8'b10011001;
            4'h5: font = 8'b01001001;
            4'h6: font = 8'b01000001;
            4'h7: font = 8'b00011111;
            4'h8: font = 8'b00000001;
            4'h9: font = 8'b00001001;
            4'hA: font = 8'b00010001;
            4'hB: font = 8'b11000001;
            4'hC: font = 8'b01100011;
            4'hD: font = 8'b10000101;
            4'hE: font = 8'b01100001;
            default: font = 8'b01110001;
        endcase
    endfunction

`ifdef SSEG_DIM_EN
    logic [3:0] pwm_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pwm_q <= 4'd0;
        else       pwm_q <= pwm_q + 4'd1;
    end

    assign pwm_on = (pwm_q <= brightness);
`else
    assign pwm_on = 1'b1;
`endif

    assign slot_end = (cnt_q == CNT_W'(REFRESH_DIV - 1));

    always_comb begin
        cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (slot_end)
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        scan_done_d = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
    end

    // A digit is blanked when it and every more-significant nibble are zero; digit 0 never is.
    always_comb begin
        lzb        = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above & (value_q[4*i +: 4] == 4'd0);
            lzb[i]     = lz_q & zero_above;
        end
    end

    always_comb begin
        nib_sel = '0;
        dp_sel  = 1'b0;
        lzb_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_sel = value_q[4*i +: 4];
                dp_sel  = dp_q[i];
                lzb_sel = lzb[i];
            end
        end
    end

    always_comb begin
        seg_d = 8'hFF;
        an_d  = '1;
        if (cnt_q >= CNT_W'(BLANK_CYCLES)) begin
            seg_d = font(nib_sel);
            if (lzb_sel) seg_d[7:1] = 7'h7F;
            if (dp_sel)  seg_d[0]   = 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++)
                an_d[i] = !((idx_q == IDX_W'(i)) && pwm_on);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            value_q     <= '0;
            dp_q        <= '0;
            lz_q        <= 1'b0;
            seg_q       <= 8'hFF;
            an_q        <= '1;
            scan_done_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            scan_done_q <= scan_done_d;
            if (load) begin
                value_q <= value;
                dp_q    <= dp_in;
                lz_q    <= lz_blank;
            end
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign scan_done = scan_done_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver with NUM_DIGITS=3, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_sseg_scan_driver;

    logic        clk;
    logic        reset;
    logic [11:0] value;
    logic [2:0]  dp_in;
    logic        load;
    logic        lz_blank;
    logic [7:0]  seg;
    logic [2:0]  an;
    logic        scan_done;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;

    sseg_scan_driver #(
        .NUM_DIGITS  (3),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .dp_in    (dp_in),
        .load     (load),
        .lz_blank (lz_blank),
        .seg      (seg),
        .an       (an),
        .scan_done(scan_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, k);
        end
    endtask

    // One clock edge; outputs sampled 1 time unit later, load is a single-edge strobe.
    task automatic step();
        @(posedge clk);
        #1;
        k++;
        load = 1'b0;
    endtask

    task automatic do_load(input logic [11:0] v, input logic [2:0] dp, input logic lz);
        value    = v;
        dp_in    = dp;
        lz_blank = lz;
        load     = 1'b1;
    endtask

    // One full 24-cycle scan starting at digit 0, c = 0; s0..s2 are the expected ON-phase segments.
    task automatic run_scan(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2);
        logic [7:0] s [3];
        logic [7:0] e_seg;
        logic [2:0] e_an;
        s[0] = s0; s[1] = s1; s[2] = s2;
        for (int j = 0; j < 24; j++) begin
            step();
            if ((j % 8) < 2) begin
                e_seg = 8'hFF;
                e_an  = 3'b111;
            end else begin
                e_seg = s[j / 8];
                e_an  = ~(3'b001 << (j / 8));
            end
            check({tag, "_seg"}, {24'd0, seg}, {24'd0, e_seg});
            check({tag, "_an"}, {29'd0, an}, {29'd0, e_an});
            check({tag, "_done"}, {31'd0, scan_done}, {31'd0, (j == 23)});
        end
    endtask

    initial begin
        int sd_cnt;
        int bad_an;
        int gap;
        int bad_gap;
        logic prev_sd;

        reset    = 1'b1;
        value    = '0;
        dp_in    = '0;
        load     = 1'b0;
        lz_blank = 1'b0;

        // Reset state
        step();
        step();
        check("rst_seg", {24'd0, seg}, 32'hFF);
        check("rst_an", {29'd0, an}, 32'h7);
        check("rst_done", {31'd0, scan_done}, 32'h0);
        reset = 1'b0;
        k     = 0;

        // Shadow cleared by reset: every digit shows 0
        run_scan("zero", 8'b00000011, 8'b00000011, 8'b00000011);

        do_load(12'hA5F, 3'b010, 1'b0);
        run_scan("a5f", 8'b01110001, 8'b01001000, 8'b00010001);

        do_load(12'h007, 3'b100, 1'b1);
        run_scan("lz007", 8'b00011111, 8'b11111111, 8'b11111110);

        do_load(12'h000, 3'b100, 1'b1);
        run_scan("lz000", 8'b00000011, 8'b11111111, 8'b11111110);

        do_load(12'h100, 3'b000, 1'b1);
        run_scan("lz100", 8'b00000011, 8'b00000011, 8'b10011111);

        // Free run of 10 scans (30 slots): pulse spacing and one-hot-low digit enables
        sd_cnt  = 0;
        bad_an  = 0;
        bad_gap = 0;
        gap     = 0;
        prev_sd = 1'b0;
        for (int j = 0; j < 240; j++) begin
            step();
            gap++;
            if ($countones(~an) > 1) bad_an++;
            if (scan_done) begin
                sd_cnt++;
                if (prev_sd || gap != 24) bad_gap++;
                gap = 0;
            end
            prev_sd = scan_done;
        end
        check("free_sd_count", sd_cnt, 10);
        check("free_sd_spacing", bad_gap, 0);
        check("free_an_onehot", bad_an, 0);

        // Reset during digit 1 ON phase
        for (int j = 0; j < 13; j++) step();
        check("mid_an_d1", {29'd0, an}, 32'h5);
        check("mid_seg_d1", {24'd0, seg}, 32'h03);
        reset = 1'b1;
        #1;
        check("async_seg", {24'd0, seg}, 32'hFF);
        check("async_an", {29'd0, an}, 32'h7);
        check("async_done", {31'd0, scan_done}, 32'h0);
        step();
        step();
        reset = 1'b0;
        k     = 0;
        // Shadow (including lz) reset: digits 1 and 2 show 0 again, scan restarts at digit 0
        run_scan("post_rst", 8'b00000011, 8'b00000011, 8'b00000011);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Parametrised multi-digit, time-multiplexed seven-segment display driver.
- Captures an N-digit hex value plus per-digit decimal points into a shadow register.
- Scans digits at a divided refresh rate and drives active-low segment and digit-enable lines directly to board pins.
- Adds blank-interval anti-ghosting, leading-zero blanking and a scan-complete pulse; sits between user logic and the display pins.

Parameters:
- NUM_DIGITS, 3, number of multiplexed digits (1..8); digit 0 is least significant.
- REFRESH_DIV, 50000, clock cycles per digit slot (>= 4).
- BLANK_CYCLES, 64, cycles at the start of each slot with all digits disabled (1..REFRESH_DIV-2).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- value  in  4*NUM_DIGITS  hex nibbles; nibble i = value[4i+3:4i] for digit i.
- dp_in  in  NUM_DIGITS  decimal point request per digit, active-high.
- load  in  1  capture strobe for value/dp_in/lz_blank.
- lz_blank  in  1  leading-zero blanking enable.
- seg  out  8  {a,b,c,d,e,f,g,dp}, active-low, registered.
- an  out  NUM_DIGITS  digit enables, active-low, at most one low, registered.
- scan_done  out  1  one-cycle pulse per full scan.

Behaviour:
- Reset (async assert) sets:
  - seg = 8'hFF, an = all ones, scan_done = 0.
  - prescaler = 0, digit index = 0.
  - shadow value/dp/lz = 0.
- Release of reset is synchronous to clk.
- Shadow: when load = 1 at edge t, value/dp_in/lz_blank are captured at t. Scan logic reads only the shadow, never the live inputs. When load is held high, the shadow is recaptured every cycle.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps to 0. At the wrap, the digit index increments from NUM_DIGITS-1 to 0.
- Slot phases, from the prescaler value c:
  - c < BLANK_CYCLES: BLANK; all an high, seg = 8'hFF.
  - Otherwise: ON; an[index] low, all other an bits high, seg = font(nibble[index]) with the dp bit cleared if shadow dp[index] = 1.
- seg/an are registered: they reflect the prescaler and index state from the previous cycle (1-cycle latency).
- Font (active-low, dp bit = 1):
  - 0=00000011, 1=10011111, 2=00100101, 3=00001101
  - 4=10011001, 5=01001001, 6=01000001, 7=00011111
  - 8=00000001, 9=00001001, A=00010001, b=11000001
  - C=01100011, d=10000101, E=01100001, F=01110001
- Leading-zero blanking (when shadow lz = 1):
  - Digit i > 0 is blanked if its nibble and every more-significant nibble are all zero.
  - A blanked digit drives seg a..g high; dp is still shown if requested, and an still follows the normal slot timing.
  - Digit 0 is never blanked.
- scan_done: high for exactly one cycle, registered, on the cycle after the index wraps NUM_DIGITS-1 -> 0.
- NUM_DIGITS = 1: index stays 0; scan_done pulses every REFRESH_DIV cycles.
- Reset mid-slot: outputs return to the reset values immediately; the scan restarts at digit 0, c = 0.
- Load mid-slot: the new nibble appears from the next registered output cycle. Tearing of the current slot is permitted, but never two an bits low.

Optional Feature:
- Macro: SSEG_DIM_EN.
- Defined:
  - Adds port brightness (in, 4 bits) and a free-running 4-bit PWM counter, reset to 0.
  - In ON phase, an[index] is low only while pwm_cnt <= brightness. brightness = 15 gives full duty; brightness = 0 gives 1/16 duty.
  - seg is unaffected.
- Undefined: no brightness port, no PWM counter; full duty throughout the ON phase.

Test Plan:
- Common setup: NUM_DIGITS=3, REFRESH_DIV=8, BLANK_CYCLES=2.
1. Reset held, then released; no load -> an=3'b111, seg=8'hFF for 3 cycles. Then an=3'b110, seg=8'b00000011 for 6 cycles, then blank for 2 cycles, then an=3'b101.
2. load with value=12'hA5F, dp_in=3'b010, lz_blank=0 -> per slot: digit0 seg=01110001, digit1 seg=01001000, digit2 seg=00010001. an one-hot-low in ON phase; all high in BLANK.
3. value=12'h007, lz_blank=1, dp_in=3'b100 -> digit0 seg=00011111, digit1 seg=11111111, digit2 seg=11111110. Repeat with value=12'h000 -> digit0 seg=00000011.
4. Free-run 100 slots -> scan_done pulses once every 24 cycles, one cycle wide. Each ON phase lasts 6 cycles, each BLANK 2; never more than one an bit low.
5. Assert reset during digit 1 ON phase -> same cycle seg=8'hFF, an=3'b111. After release, digit 0 is the first digit enabled.
6. SSEG_DIM_EN, brightness=3 -> within each ON phase an[index] is low only while pwm_cnt is 0..3. brightness=15 -> low for the whole ON phase.
